// File: rtl/alu_pkg.sv
// Shared opcode constants, state encoding and flag-mask helpers for the ALU issue controller.
package alu_pkg;

  localparam int DW_DEF = 12;

  localparam logic [2:0] OP_ABS = 3'd0;
  localparam logic [2:0] OP_SHL = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_ADD = 3'd6;
  localparam logic [2:0] OP_SUB = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  // The ALU leaves CarryOut/OV undriven for ops outside these sets.
  function automatic logic op_has_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic op_has_ov(input logic [2:0] op);
    return (op == OP_ABS) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREG x DW operand register file: host write port, priority writeback port, two async reads.
module alu_regfile #(
  parameter int DW   = 12,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_pri_en,
  input  logic [AW-1:0] i_pri_addr,
  input  logic [DW-1:0] i_pri_data,
  input  logic [AW-1:0] i_ra,
  input  logic [AW-1:0] i_rb,
  output logic [DW-1:0] o_rd_a,
  output logic [DW-1:0] o_rd_b
);

  logic [NREG-1:0][DW-1:0] r_mem;

  // Writeback beats the host on the same entry; different entries both land.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (i_pri_en && (i_pri_addr == AW'(i))) begin
          r_mem[i] <= i_pri_data;
        end else if (i_wr_en && (i_wr_addr == AW'(i))) begin
          r_mem[i] <= i_wr_data;
        end
      end
    end
  end

  assign o_rd_a = r_mem[i_ra];
  assign o_rd_b = r_mem[i_rb];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer in front of the combinational ALU.
// Optional sticky overflow flag enabled by defining ALU_STICKY_OV_EN.
//
//   state | meaning
//   IDLE  | ready for an instruction; operands latched on accept
//   EXEC  | ALU settling; result, flags and writeback captured on exit
//   WB    | result presented downstream until out_ready
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_ra,
  input  logic [AW-1:0] in_rb,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_z,
  input  logic          alu_carry,
  input  logic          alu_sign,
  input  logic          alu_ov,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          flag_c,
  output logic          flag_s,
  output logic          flag_v,
  output logic          flag_z,
  output logic          ov_sticky,
  input  logic          sticky_clr
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_accept;
  logic          w_wb;
  logic [AW-1:0] r_rd;
  logic [DW-1:0] r_alu_a;
  logic [DW-1:0] r_alu_b;
  logic [2:0]    r_alu_op;
  logic [DW-1:0] r_out_data;
  logic          r_flag_c;
  logic          r_flag_s;
  logic          r_flag_v;
  logic          r_flag_z;
  logic [DW-1:0] w_rd_a;
  logic [DW-1:0] w_rd_b;
  logic          w_flag_c;
  logic          w_flag_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    w_wb        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_wb        = 1'b1;
        w_state_nxt = WB;
      end
      WB: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  alu_regfile #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_pri_en   (w_wb),
    .i_pri_addr (r_rd),
    .i_pri_data (alu_z),
    .i_ra       (in_ra),
    .i_rb       (in_rb),
    .o_rd_a     (w_rd_a),
    .o_rd_b     (w_rd_b)
  );

  assign w_flag_c = op_has_carry(r_alu_op) & alu_carry;
  assign w_flag_v = op_has_ov(r_alu_op) & alu_ov;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd     <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
    end else if (w_accept) begin
      r_rd     <= in_rd;
      r_alu_a  <= w_rd_a;
      r_alu_b  <= w_rd_b;
      r_alu_op <= in_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data <= '0;
      r_flag_c   <= 1'b0;
      r_flag_s   <= 1'b0;
      r_flag_v   <= 1'b0;
      r_flag_z   <= 1'b0;
    end else if (w_wb) begin
      r_out_data <= alu_z;
      r_flag_c   <= w_flag_c;
      r_flag_s   <= alu_sign;
      r_flag_v   <= w_flag_v;
      r_flag_z   <= (alu_z == '0);
    end
  end

`ifdef ALU_STICKY_OV_EN
  logic r_ov_sticky;

  // A set on the writeback edge outranks a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_ov_sticky <= 1'b0;
    else if (w_wb && w_flag_v) r_ov_sticky <= 1'b1;
    else if (sticky_clr)       r_ov_sticky <= 1'b0;
  end

  assign ov_sticky = r_ov_sticky;
`else
  logic w_unused_sticky_clr;
  assign w_unused_sticky_clr = sticky_clr;
  assign ov_sticky           = 1'b0;
`endif

  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_op   = r_alu_op;
  assign out_data = r_out_data;
  assign flag_c   = r_flag_c;
  assign flag_s   = r_flag_s;
  assign flag_v   = r_flag_v;
  assign flag_z   = r_flag_z;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU stand-in and register-file model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [1:0]  in_rd = '0;
  logic [1:0]  in_ra = '0;
  logic [1:0]  in_rb = '0;
  logic [11:0] alu_a;
  logic [11:0] alu_b;
  logic [2:0]  alu_op;
  logic [11:0] alu_z;
  logic        alu_carry;
  logic        alu_sign;
  logic        alu_ov;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_data;
  logic        flag_c, flag_s, flag_v, flag_z;
  logic        ov_sticky;
  logic        sticky_clr = 1'b0;

  logic        junk_c = 1'b1;
  logic        junk_v = 1'b1;
  logic [13:0] alu_res;

  logic [11:0] mdl [4];
  logic        mdl_sticky;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_z(alu_z), .alu_carry(alu_carry), .alu_sign(alu_sign), .alu_ov(alu_ov),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flag_c(flag_c), .flag_s(flag_s), .flag_v(flag_v), .flag_z(flag_z),
    .ov_sticky(ov_sticky), .sticky_clr(sticky_clr)
  );

  // Returns {ov, carry, result}; carry on SUB means borrow.
  function automatic logic [13:0] alu_fn(input logic [2:0] op, input logic [11:0] a, input logic [11:0] b);
    int sa, sb, r;
    logic [11:0] z;
    logic c, v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = 0; z = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin r = (sa < 0) ? -sa : sa; z = r[11:0]; v = (sa == -2048); end
      3'd1: begin z = {b[10:0], 1'b0}; c = b[11]; end
      3'd2: z = a & b;
      3'd3: z = a | b;
      3'd4: z = a ^ b;
      3'd5: z = ~a;
      3'd6: begin r = int'(a) + int'(b); z = r[11:0]; c = (r > 4095); r = sa + sb; v = (r > 2047) || (r < -2048); end
      default: begin r = sa - sb; z = r[11:0]; c = (a < b); v = (r > 2047) || (r < -2048); end
    endcase
    return {v, c, z};
  endfunction

  // ALU stand-in: undriven carry/OV for other ops show up as junk so masking is exercised.
  always_comb begin
    alu_res   = alu_fn(alu_op, alu_a, alu_b);
    alu_z     = alu_res[11:0];
    alu_sign  = alu_res[11];
    alu_carry = (alu_op == 3'd6 || alu_op == 3'd7) ? alu_res[12] : junk_c;
    alu_ov    = (alu_op == 3'd0 || alu_op == 3'd6 || alu_op == 3'd7) ? alu_res[13] : junk_v;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic host_write(input logic [1:0] addr, input logic [11:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    mdl[addr] = data;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    mdl_sticky = 1'b0;
    n_vec++; if (ov_sticky !== mdl_sticky) begin n_err++; $display("FAIL sticky_after_clr got=%b exp=%b", ov_sticky, mdl_sticky); end
  endtask

  // hw_phase: 0 none, 1 host write on accept edge, 2 host write on writeback edge.
  task automatic run_instr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb,
                           input int hold, input int hw_phase, input logic [1:0] hw_addr,
                           input logic [11:0] hw_data, input logic clr);
    logic [13:0] res;
    logic [11:0] ea, eb, ez;
    logic        ec, ev;
    logic [3:0]  ef;
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL in_ready_idle got=%b exp=1", in_ready); end
    ea = mdl[ra]; eb = mdl[rb];
    res = alu_fn(op, ea, eb);
    ez = res[11:0];
    ec = (op == 3'd6 || op == 3'd7) && res[12];
    ev = (op == 3'd0 || op == 3'd6 || op == 3'd7) && res[13];
    ef = {ec, ez[11], ev, (ez == 12'd0)};
    in_valid = 1'b1; in_op = op; in_rd = rd; in_ra = ra; in_rb = rb;
    if (hw_phase == 1) begin wr_en = 1'b1; wr_addr = hw_addr; wr_data = hw_data; end
    @(negedge clk);
    if (hw_phase == 1) mdl[hw_addr] = hw_data;
    in_valid = 1'b0; wr_en = 1'b0;
    n_vec++; if (alu_a !== ea) begin n_err++; $display("FAIL alu_a got=%h exp=%h", alu_a, ea); end
    n_vec++; if (alu_b !== eb) begin n_err++; $display("FAIL alu_b got=%h exp=%h", alu_b, eb); end
    n_vec++; if (alu_op !== op) begin n_err++; $display("FAIL alu_op got=%0d exp=%0d", alu_op, op); end
    n_vec++; if ({out_valid, in_ready} !== 2'b00) begin n_err++; $display("FAIL exec_hs got=%b exp=00", {out_valid, in_ready}); end
    sticky_clr = clr;
    if (hw_phase == 2) begin wr_en = 1'b1; wr_addr = hw_addr; wr_data = hw_data; end
    @(negedge clk);
    sticky_clr = 1'b0; wr_en = 1'b0;
    if (hw_phase == 2 && hw_addr != rd) mdl[hw_addr] = hw_data;
    mdl[rd] = ez;
`ifdef ALU_STICKY_OV_EN
    if (ev) mdl_sticky = 1'b1;
    else if (clr) mdl_sticky = 1'b0;
`endif
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL out_valid_wb got=%b exp=1", out_valid); end
    n_vec++; if (out_data !== ez) begin n_err++; $display("FAIL out_data got=%h exp=%h op=%0d", out_data, ez, op); end
    n_vec++; if ({flag_c, flag_s, flag_v, flag_z} !== ef) begin n_err++; $display("FAIL flags_csvz got=%b exp=%b op=%0d", {flag_c, flag_s, flag_v, flag_z}, ef, op); end
    n_vec++; if (ov_sticky !== mdl_sticky) begin n_err++; $display("FAIL ov_sticky got=%b exp=%b", ov_sticky, mdl_sticky); end
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1; in_op = 3'($urandom); in_ra = 2'($urandom); in_rb = 2'($urandom);
      @(negedge clk);
      n_vec++; if ({out_valid, in_ready} !== 2'b10) begin n_err++; $display("FAIL hold_hs got=%b exp=10", {out_valid, in_ready}); end
      n_vec++; if ({out_data, flag_c, flag_s, flag_v, flag_z} !== {ez, ef}) begin n_err++; $display("FAIL hold_stable got=%h exp=%h", {out_data, flag_c, flag_s, flag_v, flag_z}, {ez, ef}); end
      n_vec++; if ({alu_a, alu_op} !== {ea, op}) begin n_err++; $display("FAIL hold_alu got=%h exp=%h", {alu_a, alu_op}, {ea, op}); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL release_hs got=%b exp=01", {out_valid, in_ready}); end
    n_vec++; if (out_data !== ez) begin n_err++; $display("FAIL out_data_persist got=%h exp=%h", out_data, ez); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    mdl_sticky = 1'b0;
    @(negedge clk);
    n_vec++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL reset_hs got=%b exp=10", {in_ready, out_valid}); end
    n_vec++; if ({alu_a, alu_b, alu_op} !== 27'd0) begin n_err++; $display("FAIL reset_alu got=%h exp=0", {alu_a, alu_b, alu_op}); end
    n_vec++; if ({out_data, flag_c, flag_s, flag_v, flag_z, ov_sticky} !== 17'd0) begin n_err++; $display("FAIL reset_out got=%h exp=0", {out_data, flag_c, flag_s, flag_v, flag_z, ov_sticky}); end
    rst = 1'b0;
  endtask

  task automatic test_add_ovf();
    host_write(2'd0, 12'h7FF);
    host_write(2'd1, 12'h001);
    run_instr(3'd6, 2'd2, 2'd0, 2'd1, 0, 0, 2'd0, 12'h0, 1'b0);
    n_vec++; if (out_data !== 12'h800) begin n_err++; $display("FAIL add_data got=%h exp=800", out_data); end
    n_vec++; if ({flag_c, flag_s, flag_v, flag_z} !== 4'b0110) begin n_err++; $display("FAIL add_flags got=%b exp=0110", {flag_c, flag_s, flag_v, flag_z}); end
    run_instr(3'd3, 2'd3, 2'd2, 2'd2, 0, 0, 2'd0, 12'h0, 1'b0);
    n_vec++; if (out_data !== 12'h800) begin n_err++; $display("FAIL add_r2 got=%h exp=800", out_data); end
  endtask

  task automatic test_sub_zero();
    host_write(2'd0, 12'h005);
    host_write(2'd1, 12'h005);
    run_instr(3'd7, 2'd0, 2'd0, 2'd1, 0, 0, 2'd0, 12'h0, 1'b0);
    n_vec++; if ({out_data, flag_c, flag_v, flag_z} !== {12'h000, 3'b001}) begin n_err++; $display("FAIL sub_zero got=%h exp=001", {out_data, flag_c, flag_v, flag_z}); end
    run_instr(3'd3, 2'd1, 2'd0, 2'd0, 0, 0, 2'd0, 12'h0, 1'b0);
    n_vec++; if (out_data !== 12'h000) begin n_err++; $display("FAIL sub_r0 got=%h exp=000", out_data); end
  endtask

  task automatic test_abs_shl();
    junk_c = 1'b1; junk_v = 1'b1;
    host_write(2'd3, 12'h800);
    run_instr(3'd0, 2'd1, 2'd3, 2'd3, 0, 0, 2'd0, 12'h0, 1'b0);
    n_vec++; if ({out_data, flag_v} !== {12'h800, 1'b1}) begin n_err++; $display("FAIL abs got=%h exp=%h", {out_data, flag_v}, {12'h800, 1'b1}); end
    host_write(2'd2, 12'h801);
    run_instr(3'd1, 2'd0, 2'd1, 2'd2, 0, 0, 2'd0, 12'h0, 1'b0);
    n_vec++; if ({out_data, flag_c, flag_v} !== {12'h002, 2'b00}) begin n_err++; $display("FAIL shl_masked got=%h exp=%h", {out_data, flag_c, flag_v}, {12'h002, 2'b00}); end
  endtask

  task automatic test_backpressure();
    run_instr(3'd4, 2'd3, 2'd1, 2'd2, 5, 0, 2'd0, 12'h0, 1'b0);
    run_instr(3'd5, 2'd2, 2'd3, 2'd0, 0, 0, 2'd0, 12'h0, 1'b0);
  endtask

  task automatic test_collision();
    host_write(2'd0, 12'h123);
    host_write(2'd1, 12'h0F0);
    run_instr(3'd6, 2'd2, 2'd0, 2'd1, 0, 2, 2'd2, 12'hABC, 1'b0);
    run_instr(3'd3, 2'd3, 2'd2, 2'd2, 0, 0, 2'd0, 12'h0, 1'b0);
    n_vec++; if (out_data !== 12'h213) begin n_err++; $display("FAIL collision_r2 got=%h exp=213", out_data); end
    run_instr(3'd2, 2'd0, 2'd0, 2'd1, 0, 1, 2'd0, 12'hFFF, 1'b0);
    run_instr(3'd3, 2'd1, 2'd0, 2'd0, 0, 0, 2'd0, 12'h0, 1'b0);
  endtask

  task automatic test_reset_exec();
    host_write(2'd1, 12'h3C3);
    host_write(2'd2, 12'h155);
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd6; in_rd = 2'd3; in_ra = 2'd1; in_rb = 2'd2;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL rst_exec_hs got=%b exp=10", {in_ready, out_valid}); end
    n_vec++; if ({alu_a, alu_b, alu_op, out_data, flag_c, flag_s, flag_v, flag_z, ov_sticky} !== 44'd0) begin n_err++; $display("FAIL rst_exec_regs got=%h exp=0", {alu_a, alu_b, alu_op, out_data, flag_c, flag_s, flag_v, flag_z, ov_sticky}); end
    @(negedge clk);
    n_vec++; if ({in_ready, out_valid, out_data} !== {2'b10, 12'h000}) begin n_err++; $display("FAIL rst_exec_nowb got=%h exp=%h", {in_ready, out_valid, out_data}, {2'b10, 12'h000}); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    mdl_sticky = 1'b0;
    for (int i = 0; i < 4; i++) run_instr(3'd3, 2'(i), 2'(i), 2'(i), 0, 0, 2'd0, 12'h0, 1'b0);
  endtask

  task automatic test_sticky();
    pulse_clr();
    host_write(2'd0, 12'h7FF);
    host_write(2'd1, 12'h001);
    run_instr(3'd6, 2'd2, 2'd0, 2'd1, 0, 0, 2'd0, 12'h0, 1'b0);
    run_instr(3'd2, 2'd3, 2'd0, 2'd1, 0, 0, 2'd0, 12'h0, 1'b0);
    pulse_clr();
    run_instr(3'd6, 2'd2, 2'd0, 2'd1, 0, 0, 2'd0, 12'h0, 1'b1);
    run_instr(3'd2, 2'd3, 2'd0, 2'd1, 0, 0, 2'd0, 12'h0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      junk_c = 1'($urandom); junk_v = 1'($urandom);
      if ($urandom_range(0, 2) == 0) host_write(2'($urandom), 12'($urandom));
      run_instr(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), $urandom_range(0, 2),
                $urandom_range(0, 2), 2'($urandom), 12'($urandom), 1'($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_sub_zero();
    test_abs_shl();
    test_backpressure();
    test_collision();
    test_sticky();
    test_reset_exec();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencing stage directly upstream of the team's 12-bit combinational ALU (8 ops, Z/CarryOut/Sign/OV outputs).
- Holds a small operand register file, accepts register-to-register instructions over valid/ready, and drives the ALU A/B/OP from registered values.
- Captures the ALU result and flags one cycle later, writes the result back to the destination register, and presents it downstream over a valid/ready result port.

Parameters:
- DW, 12, datapath width; must match the ALU width.
- NREG, 4, number of operand registers (power of two).
- AW, 2, register address width, equal to log2(NREG).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  host register load strobe.
- wr_addr  in  AW  host load address.
- wr_data  in  DW  host load data.
- in_valid  in  1  instruction valid.
- in_ready  out  1  controller can accept an instruction.
- in_op  in  3  ALU opcode (0 ABS, 1 SHL B, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 ADD, 7 SUB).
- in_rd  in  AW  destination register.
- in_ra  in  AW  source register for A.
- in_rb  in  AW  source register for B.
- alu_a  out  DW  registered operand A to the ALU.
- alu_b  out  DW  registered operand B to the ALU.
- alu_op  out  3  registered opcode to the ALU.
- alu_z  in  DW  ALU result.
- alu_carry  in  1  ALU CarryOut.
- alu_sign  in  1  ALU Sign.
- alu_ov  in  1  ALU OV.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DW  captured result.
- flag_c  out  1  carry flag.
- flag_s  out  1  sign flag.
- flag_v  out  1  overflow flag.
- flag_z  out  1  zero flag.
- ov_sticky  out  1  sticky overflow (see Optional Feature).
- sticky_clr  in  1  clears ov_sticky.

Behaviour:
- Reset, asynchronous on rst high, effective immediately:
  - State goes to IDLE.
  - All registers, alu_a, alu_b, alu_op, out_data, all flags and ov_sticky go to 0.
  - out_valid goes to 0 and in_ready goes to 1 (the latter being the IDLE value).
  - Reset mid-operation discards the instruction in flight; no writeback occurs.
- FSM has three states: IDLE, EXEC, WB.
  - IDLE: in_ready=1. When in_valid is high, on that edge latch alu_a=reg[in_ra], alu_b=reg[in_rb], alu_op=in_op and the rd copy; go to EXEC.
  - EXEC: in_ready=0. The ALU settles combinationally. On the next edge:
    - capture out_data=alu_z and reg[rd]=alu_z;
    - capture flag_s=alu_sign and flag_z=(alu_z==0);
    - capture flag_c=alu_carry for op 6/7, otherwise 0;
    - capture flag_v=alu_ov for op 0/6/7, otherwise 0 (the ALU does not drive OV/CarryOut for the remaining ops, so the controller masks them);
    - go to WB.
  - WB: out_valid=1, with out_data and flags held stable. When out_ready is high go to IDLE; in_ready stays 0 until back in IDLE.
- Throughput is one instruction per 3 cycles minimum. Latency from accept edge to out_valid is 2 edges.
- Operand read is read-before-write. A host write on the accept edge to in_ra/in_rb does not affect operands latched on that edge.
- Host write is accepted in any state. If it collides with the EXEC→WB writeback to the same address, the ALU writeback wins and the host write is dropped.
- rd may equal ra or rb. The result overwrites the register after the operands have already been latched.
- Flags and out_data persist until the next writeback. alu_* outputs hold their values in WB and IDLE.

Optional Feature:
- Macro: ALU_STICKY_OV_EN.
- Defined: ov_sticky sets on any writeback where masked flag_v=1 and stays set until sticky_clr is high at a clock edge. If set and clear coincide, set wins.
- Undefined: ov_sticky is tied to 0 and sticky_clr is ignored.

Decomposition:
- Package alu_pkg:
  - opcode constants OP_ABS..OP_SUB;
  - state encoding IDLE/EXEC/WB;
  - DW default.
- Sub-module alu_regfile (NREG x DW):
  - one write port with collision priority input;
  - two asynchronous read ports.

Test Plan:
- Load r0=12'h7FF and r1=12'h001, issue ADD rd=2 ra=0 rb=1 → out_data=12'h800, flag_v=1, flag_s=1, flag_c=0, flag_z=0, r2=12'h800, out_valid 2 edges after accept.
- r0=12'h005 and r1=12'h005, issue SUB rd=0 → out_data=0, flag_z=1, flag_c=0, flag_v=0; r0 becomes 0 after WB.
- ABS on r3=12'h800 → out_data=12'h800, flag_v=1. Then issue SHL on B=12'h801 → out_data=12'h002, flag_c=0, flag_v=0 (masked).
- Hold out_ready=0 for 5 cycles in WB → out_valid, out_data and flags stable; in_ready=0; in_valid ignored. Release → IDLE, then next accept.
- Host write to r2 on the same edge as the writeback to r2 → the ALU result remains in r2. Assert rst during EXEC → out_valid=0, all registers 0, in_ready=1 immediately.
- With ALU_STICKY_OV_EN: an overflow ADD sets ov_sticky; a following non-overflow AND leaves it at 1; sticky_clr clears it. Without the macro, ov_sticky stays 0 throughout.
